folded_fir: RTL and testbench

FOLDED_FIR -- requirements
Module: folded_fir

---
 rtl/folded_fir_pkg.sv | 38 +++
 rtl/folded_fir_if.sv | 15 +
 rtl/folded_fir_mac.sv | 31 +++
 rtl/folded_fir.sv | 86 ++++++++
 tb/tb_folded_fir.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/folded_fir_pkg.sv
// Shared constants for the folded FIR: widths, tap count, fixed coefficient set
// and the output rounding/saturation helper.
package folded_fir_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int ORDER       = 15;
    localparam int TAPS        = ORDER + 1;
    localparam int COEF_WIDTH  = 16;
    localparam int ACC_WIDTH   = 36;
    localparam int PHASE_WIDTH = $clog2(TAPS);

    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    // Symmetric low-pass; sum(h) = 47200/32768 > 1, so full-scale inputs clamp.
    localparam coef_t COEFS [TAPS] = '{
        -16'sd300, -16'sd600,   16'sd0, 16'sd1500, 16'sd3000, 16'sd5000, 16'sd7000, 16'sd8000,
         16'sd8000, 16'sd7000, 16'sd5000, 16'sd3000, 16'sd1500,   16'sd0, -16'sd600, -16'sd300
    };

    localparam logic signed [ACC_WIDTH-1:0] ROUND_K = ACC_WIDTH'(16384);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

    function automatic logic signed [DATA_WIDTH-1:0] scale_acc(
        input logic signed [ACC_WIDTH-1:0] acc
    );
        logic signed [ACC_WIDTH-1:0] shifted;
        shifted = (acc + ROUND_K) >>> 15;
        if (shifted > SAT_MAX) begin
            scale_acc = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            scale_acc = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            scale_acc = shifted[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/folded_fir_if.sv
// Sample stream interface between the FIR and its environment.
interface folded_fir_if #(
    parameter int DATA_WIDTH = 16
);
    // sample_in pulses one cycle: the master presents din/en in that cycle and the
    // FIR captures on the closing edge; sample_out pulses in the cycle dout is new.
    logic                         en;
    logic signed [DATA_WIDTH-1:0] din;
    logic signed [DATA_WIDTH-1:0] dout;
    logic                         sample_in;
    logic                         sample_out;

    modport master (output en, output din, input dout, input sample_in, input sample_out);
    modport slave  (input en, input din, output dout, output sample_in, output sample_out);
endinterface

// File: rtl/folded_fir_mac.sv
// Signed multiply-accumulate; clr restarts the sum with the current product.
module fir_mac
    import folded_fir_pkg::*;
#(
    parameter int A_WIDTH = DATA_WIDTH,
    parameter int B_WIDTH = COEF_WIDTH,
    parameter int ACC_W   = ACC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic signed [A_WIDTH-1:0] a_i,
    input  logic signed [B_WIDTH-1:0] b_i,
    output logic signed [ACC_W-1:0]   acc_o
);
    logic signed [A_WIDTH+B_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]           acc_q, acc_d;

    assign prod = a_i * b_i;

    always_comb begin
        acc_d = clr_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/folded_fir.sv
// Folded FIR: one MAC walks the taps one per cycle; phase 0 uses the incoming
// sample directly so the full sum is ready when the next phase 0 begins.
module folded_fir
    import folded_fir_pkg::*;
#(
    parameter int DATA_WIDTH = folded_fir_pkg::DATA_WIDTH,
    parameter int ORDER      = folded_fir_pkg::ORDER,
    parameter int COEF_WIDTH = folded_fir_pkg::COEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    folded_fir_if.slave  bus
);
    localparam int NTAPS = ORDER + 1;
    localparam int PW    = $clog2(NTAPS);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    sample_t                       dline_q [NTAPS];
    sample_t                       dline_d [NTAPS];
    logic [PW-1:0]                 phase_q, phase_d;
    logic                          run_q, run_d;
    logic                          sample_in_q, sample_in_d;
    logic                          acc_full_q, acc_full_d;
    logic                          sample_out_q, sample_out_d;
    sample_t                       dout_q, dout_d;
    sample_t                       din_gated, tap_x;
    logic signed [COEF_WIDTH-1:0]  tap_h;
    logic signed [ACC_WIDTH-1:0]   acc;

    // run_q holds phase at 0 for the first edge after reset so sample_in rises with it.
    always_comb begin
        din_gated    = bus.en ? bus.din : '0;
        run_d        = 1'b1;
        phase_d      = '0;
        if (run_q) phase_d = (phase_q == PW'(NTAPS-1)) ? '0 : phase_q + 1'b1;
        sample_in_d  = (phase_d == '0);
        acc_full_d   = run_q && (phase_q == PW'(NTAPS-1));
        sample_out_d = acc_full_q;
        dout_d       = acc_full_q ? scale_acc(acc) : dout_q;
        dline_d      = dline_q;
        if (sample_in_q) begin
            for (int i = NTAPS-1; i > 0; i--) dline_d[i] = dline_q[i-1];
            dline_d[0] = din_gated;
        end
        tap_x = (phase_q == '0) ? din_gated : dline_q[phase_q];
        tap_h = COEFS[phase_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            run_q        <= 1'b0;
            sample_in_q  <= 1'b0;
            acc_full_q   <= 1'b0;
            sample_out_q <= 1'b0;
            dout_q       <= '0;
            for (int i = 0; i < NTAPS; i++) dline_q[i] <= '0;
        end else begin
            phase_q      <= phase_d;
            run_q        <= run_d;
            sample_in_q  <= sample_in_d;
            acc_full_q   <= acc_full_d;
            sample_out_q <= sample_out_d;
            dout_q       <= dout_d;
            dline_q      <= dline_d;
        end
    end

    fir_mac #(
        .A_WIDTH (DATA_WIDTH),
        .B_WIDTH (COEF_WIDTH),
        .ACC_W   (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (phase_q == '0),
        .a_i   (tap_x),
        .b_i   (tap_h),
        .acc_o (acc)
    );

    assign bus.dout       = dout_q;
    assign bus.sample_in  = sample_in_q;
    assign bus.sample_out = sample_out_q;
endmodule

// File: tb/tb_folded_fir.sv
// Directed bench for folded_fir: reference convolution model feeding an expected
// queue, strobe timing tracked per cycle, constant checks at the boundaries.
module tb_folded_fir;
    localparam int DW = 16;
    localparam int NT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    folded_fir_if #(.DATA_WIDTH(DW)) bus ();

    folded_fir dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int h_ref [NT] = '{-300, -600, 0, 1500, 3000, 5000, 7000, 8000,
                       8000, 7000, 5000, 3000, 1500, 0, -600, -300};
    int            hist [NT];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_dout = '0;
    int            tests_run = 0;
    int            tests_failed = 0;
    int            cyc = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_sample(input logic e, input logic [DW-1:0] x);
        longint acc;
        acc = 0;
        for (int k = NT-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = e ? int'($signed(x)) : 0;
        for (int k = 0; k < NT; k++) acc += longint'(h_ref[k]) * longint'(hist[k]);
        acc = (acc + 16384) >>> 15;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        exp_q.push_back(DW'(acc));
    endtask

    task automatic drive_sample(input logic e, input logic [DW-1:0] x);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.sample_in && waited < 3*NT);
        check("sample_in_wait", DW'(bus.sample_in), DW'(1));
        if (!bus.sample_in) return;
        bus.en  = e;
        bus.din = x;
        push_sample(e, x);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        for (int k = 0; k < NT; k++) hist[k] = 0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: cyc counts cycles since reset release, cycle 0 being sample_in's first pulse.
    always @(posedge clk) begin
        logic [DW-1:0] exp_v;
        #1;
        if (rst) begin
            cyc = 0;
            last_dout = '0;
            check("rst_dout", bus.dout, '0);
            check("rst_sample_in", DW'(bus.sample_in), '0);
            check("rst_sample_out", DW'(bus.sample_out), '0);
        end else begin
            check("sample_in_timing", DW'(bus.sample_in), DW'(cyc % NT == 0));
            check("sample_out_timing", DW'(bus.sample_out), DW'(cyc >= NT+1 && cyc % NT == 1));
            if (bus.sample_out) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $error("FAIL unexpected_out: observed dout %0h expected no output", bus.dout);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("dout", bus.dout, exp_v);
                    last_dout = exp_v;
                end
            end else begin
                check("dout_hold", bus.dout, last_dout);
            end
            cyc++;
        end
    end

    initial begin
        bus.en  = 1'b0;
        bus.din = '0;
        for (int k = 0; k < NT; k++) hist[k] = 0;

        do_reset(3);

        // Impulse, then zeros: dout shows the scaled coefficients and returns to 0.
        drive_sample(1'b1, 16'h7FFF);
        repeat (19) drive_sample(1'b1, 16'h0000);
        check("impulse_tail", bus.dout, 16'h0000);

        // Half-scale step settles at 0.5*sum(h) = 23600.
        do_reset(2);
        repeat (20) drive_sample(1'b1, 16'h4000);
        check("step_steady", bus.dout, 16'h5C30);

        // Full-scale positive then negative: clamps without wrapping.
        repeat (20) drive_sample(1'b1, 16'h7FFF);
        check("sat_pos_clamp", bus.dout, 16'h7FFF);
        repeat (20) drive_sample(1'b1, 16'h8000);
        check("sat_neg_clamp", bus.dout, 16'h8000);

        // Random history, then en=0 with nonzero din: output decays to 0.
        repeat (16) drive_sample(1'b1, DW'($urandom_range(0, 65535)));
        repeat (20) drive_sample(1'b0, DW'($urandom_range(1, 65535)));
        check("en_off_decay", bus.dout, 16'h0000);

        // Reset mid-accumulation; the following run must match zero history.
        repeat (8) drive_sample(1'b1, DW'($urandom_range(0, 65535)));
        repeat (5) @(negedge clk);
        do_reset(2);
        repeat (20) drive_sample(1'b1, DW'($urandom_range(0, 65535)));

        // Let the last sample's result emerge before the next unmodelled capture.
        repeat (NT + 4) @(negedge clk);
        check("queue_drained", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
